control_unit_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute controller driving every control input of the ALU datapath system.

---
 rtl/control_unit_sequencer_pkg.sv | 83 ++++++++
 rtl/control_unit_sequencer_decoder.sv | 92 +++++++++
 rtl/control_unit_sequencer.sv | 117 +++++++++++
 tb/tb_control_unit_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_sequencer_pkg.sv
// Shared opcodes, FSM states, datapath control encodings and control-word type
// for the fetch/decode/execute sequencer.
package cu_pkg;

  localparam logic [5:0] OP_BRA  = 6'h00;
  localparam logic [5:0] OP_BNE  = 6'h02;
  localparam logic [5:0] OP_ADD  = 6'h0A;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_STB  = 6'h11;
  localparam logic [5:0] OP_MOVL = 6'h12;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALT    = 3'd4
  } cu_state_e;

  localparam logic [2:0] RF_FUN_LOAD     = 3'b010;
  localparam logic [2:0] RF_FUN_CLEAR    = 3'b011;
  localparam logic [2:0] RF_FUN_LOAD_ZX  = 3'b100;
  localparam logic [2:0] RF_FUN_LOAD_LOW = 3'b101;
  localparam logic [3:0] RF_SEL_NONE     = 4'b0000;
  localparam logic [3:0] RF_SEL_ALL      = 4'b1111;

  localparam logic [2:0] ARF_FUN_INC   = 3'b001;
  localparam logic [2:0] ARF_FUN_LOAD  = 3'b010;
  localparam logic [2:0] ARF_FUN_CLEAR = 3'b011;
  localparam logic [2:0] ARF_SEL_NONE  = 3'b000;
  localparam logic [2:0] ARF_SEL_PC    = 3'b100;
  localparam logic [2:0] ARF_SEL_ALL   = 3'b111;
  localparam logic [1:0] ARF_OUT_PC    = 2'b00;
  localparam logic [1:0] ARF_OUT_AR    = 2'b10;

  localparam logic [4:0] ALU_PASS_A = 5'b00000;
  localparam logic [4:0] ALU_ADD    = 5'b00100;

  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b10;
  localparam logic [1:0] MUXA_IMM = 2'b11;
  localparam logic [1:0] MUXB_IMM = 2'b11;
  localparam logic       MUXC_LOW = 1'b0;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [2:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] rf_scr_sel;
    logic [4:0] alu_fun_sel;
    logic       alu_wf;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [2:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_word_t;

  // Nothing written, memory deselected, all selects parked at zero.
  function automatic ctrl_word_t idle_word();
    ctrl_word_t cw;
    cw            = '0;
    cw.rf_reg_sel = RF_SEL_NONE;
    cw.rf_scr_sel = RF_SEL_NONE;
    cw.arf_reg_sel = ARF_SEL_NONE;
    cw.mem_cs     = 1'b1;
    return cw;
  endfunction

  function automatic logic op_defined(input logic [5:0] op);
    return (op == OP_BRA) || (op == OP_BNE) || (op == OP_ADD) || (op == OP_LDB) ||
           (op == OP_STB) || (op == OP_MOVL) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/control_unit_sequencer_decoder.sv
// Combinational control-word decode from sequencer state, instruction and ALU flags.
module cu_decoder
  import cu_pkg::*;
(
  input  cu_state_e   state,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output ctrl_word_t  cw
);

  logic [5:0] opcode;
  logic [1:0] rsel;
  logic [2:0] dst;
  logic [2:0] src_a;
  logic [2:0] src_b;
  logic       zero_flag;
  logic       unused_flags;

  assign opcode       = ir[15:10];
  assign rsel         = ir[9:8];
  assign dst          = ir[8:6];
  assign src_a        = ir[5:3];
  assign src_b        = ir[2:0];
  assign zero_flag    = flags[3];
  assign unused_flags = ^flags[2:0];

  always_comb begin
    cw = idle_word();
    unique case (state)
      ST_INIT: begin
        cw.rf_fun_sel  = RF_FUN_CLEAR;
        cw.rf_reg_sel  = RF_SEL_ALL;
        cw.rf_scr_sel  = RF_SEL_ALL;
        cw.arf_fun_sel = ARF_FUN_CLEAR;
        cw.arf_reg_sel = ARF_SEL_ALL;
      end
      ST_FETCH_L, ST_FETCH_H: begin
        cw.arf_out_d_sel = ARF_OUT_PC;
        cw.mem_cs        = 1'b0;
        cw.ir_write      = 1'b1;
        cw.ir_lh         = (state == ST_FETCH_H);
        cw.arf_fun_sel   = ARF_FUN_INC;
        cw.arf_reg_sel   = ARF_SEL_PC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_BRA, OP_BNE: begin
            if (opcode == OP_BRA || !zero_flag) begin
              cw.mux_b_sel   = MUXB_IMM;
              cw.arf_fun_sel = ARF_FUN_LOAD;
              cw.arf_reg_sel = ARF_SEL_PC;
            end
          end
          OP_ADD: begin
            cw.rf_out_a_sel = src_a;
            cw.rf_out_b_sel = src_b;
            cw.alu_fun_sel  = ALU_ADD;
            cw.alu_wf       = 1'b1;
            cw.mux_a_sel    = MUXA_ALU;
            cw.rf_fun_sel   = RF_FUN_LOAD;
            // Destination codes 4..7 address the scratch bank.
            if (dst[2]) cw.rf_scr_sel = 4'b0001 << dst[1:0];
            else        cw.rf_reg_sel = 4'b0001 << dst[1:0];
          end
          OP_LDB: begin
            cw.arf_out_d_sel = ARF_OUT_AR;
            cw.mem_cs        = 1'b0;
            cw.mux_a_sel     = MUXA_MEM;
            cw.rf_fun_sel    = RF_FUN_LOAD_ZX;
            cw.rf_reg_sel    = 4'b0001 << rsel;
          end
          OP_STB: begin
            cw.rf_out_a_sel  = {1'b0, rsel};
            cw.alu_fun_sel   = ALU_PASS_A;
            cw.mux_c_sel     = MUXC_LOW;
            cw.arf_out_d_sel = ARF_OUT_AR;
            cw.mem_cs        = 1'b0;
            cw.mem_wr        = 1'b1;
          end
          OP_MOVL: begin
            cw.mux_a_sel  = MUXA_IMM;
            cw.rf_fun_sel = RF_FUN_LOAD_LOW;
            cw.rf_reg_sel = 4'b0001 << rsel;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: holds FSM state and T-step counter.
// Optional CU_ILLEGAL_TRAP_EN: undefined opcodes halt instead of acting as NOPs.
//
//  state    | meaning
//  INIT     | one cycle clearing all RF/ARF registers after reset
//  FETCH_L  | T0: read low instruction byte at PC into IR, PC++
//  FETCH_H  | T1: read high instruction byte at PC into IR, PC++
//  EXEC     | T2: execute decoded IROut, then back to FETCH_L
//  HALT     | idle forever with Halted=1 until reset
module control_unit_sequencer
  import cu_pkg::*;
#(
  parameter int SC_WIDTH   = 3,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [15:0]         IROut,
  input  logic [3:0]          FlagsOut,
  output logic [2:0]          RF_OutASel,
  output logic [2:0]          RF_OutBSel,
  output logic [2:0]          RF_FunSel,
  output logic [3:0]          RF_RegSel,
  output logic [3:0]          RF_ScrSel,
  output logic [4:0]          ALU_FunSel,
  output logic                ALU_WF,
  output logic [1:0]          ARF_OutCSel,
  output logic [1:0]          ARF_OutDSel,
  output logic [2:0]          ARF_FunSel,
  output logic [2:0]          ARF_RegSel,
  output logic                IR_LH,
  output logic                IR_Write,
  output logic                Mem_WR,
  output logic                Mem_CS,
  output logic [1:0]          MuxASel,
  output logic [1:0]          MuxBSel,
  output logic                MuxCSel,
  output logic [SC_WIDTH-1:0] SC,
  output logic                Halted
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif

  localparam cu_state_e RESET_STATE = INIT_CLEAR ? ST_INIT : ST_FETCH_L;

  cu_state_e           state;
  logic [SC_WIDTH-1:0] sc_q;
  ctrl_word_t          cw;
  logic                exec_halts;

  assign exec_halts = (IROut[15:10] == OP_HLT) ||
                      (TRAP_ILLEGAL && !op_defined(IROut[15:10]));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= RESET_STATE;
      sc_q  <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          state <= ST_FETCH_L;
          sc_q  <= '0;
        end
        ST_FETCH_L: begin
          state <= ST_FETCH_H;
          sc_q  <= sc_q + SC_WIDTH'(1);
        end
        ST_FETCH_H: begin
          state <= ST_EXEC;
          sc_q  <= sc_q + SC_WIDTH'(1);
        end
        ST_EXEC: begin
          state <= exec_halts ? ST_HALT : ST_FETCH_L;
          sc_q  <= '0;
        end
        ST_HALT: ;
        default: begin
          state <= RESET_STATE;
          sc_q  <= '0;
        end
      endcase
    end
  end

  cu_decoder u_decoder (
    .state (state),
    .ir    (IROut),
    .flags (FlagsOut),
    .cw    (cw)
  );

  assign RF_OutASel  = cw.rf_out_a_sel;
  assign RF_OutBSel  = cw.rf_out_b_sel;
  assign RF_FunSel   = cw.rf_fun_sel;
  assign RF_RegSel   = cw.rf_reg_sel;
  assign RF_ScrSel   = cw.rf_scr_sel;
  assign ALU_FunSel  = cw.alu_fun_sel;
  assign ALU_WF      = cw.alu_wf;
  assign ARF_OutCSel = cw.arf_out_c_sel;
  assign ARF_OutDSel = cw.arf_out_d_sel;
  assign ARF_FunSel  = cw.arf_fun_sel;
  assign ARF_RegSel  = cw.arf_reg_sel;
  assign IR_LH       = cw.ir_lh;
  assign IR_Write    = cw.ir_write;
  assign Mem_WR      = cw.mem_wr;
  assign Mem_CS      = cw.mem_cs;
  assign MuxASel     = cw.mux_a_sel;
  assign MuxBSel     = cw.mux_b_sel;
  assign MuxCSel     = cw.mux_c_sel;
  assign SC          = sc_q;
  assign Halted      = (state == ST_HALT);

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Self-checking bench for control_unit_sequencer: instruction vector table with an
// expected-word scoreboard, plus reset, undefined-opcode, mid-fetch reset and halt sequences.
module tb_control_unit_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IROut = 16'h0000;
  logic [3:0]  FlagsOut = 4'h0;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SC;
  logic        Halted;

  always #5 Clock = ~Clock;

  control_unit_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .SC(SC), .Halted(Halted)
  );

  typedef struct packed {
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu;
    logic       wf;
    logic [1:0] c_sel;
    logic [1:0] d_sel;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_wr;
    logic       wr;
    logic       cs;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
  } cw_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flags;
    cw_t         exp;
  } vec_t;

  cw_t  exp_q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  function automatic cw_t snap();
    return '{RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
             ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH,
             IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel};
  endfunction

  function automatic cw_t idle_cw();
    cw_t c = '0;
    c.cs = 1'b1;
    return c;
  endfunction

  function automatic cw_t fetch_cw(input logic lh);
    cw_t c = '0;
    c.cs = 1'b0; c.ir_wr = 1'b1; c.ir_lh = lh;
    c.d_sel = 2'b00; c.arf_fun = 3'b001; c.arf_reg = 3'b100;
    return c;
  endfunction

  function automatic cw_t init_cw();
    cw_t c = idle_cw();
    c.rf_fun = 3'b011; c.rf_reg = 4'b1111; c.rf_scr = 4'b1111;
    c.arf_fun = 3'b011; c.arf_reg = 3'b111;
    return c;
  endfunction

  task automatic check_cw(input string nm, input cw_t exp);
    cw_t got = snap();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: control word got %h required %h", nm, got, exp);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  // Starts an instruction from FETCH_L; ends one cycle after its T2 step.
  task automatic run_instr(input string nm, input logic [15:0] ir, input logic [3:0] fl,
                           input cw_t exp);
    int n = 0;
    cw_t e;
    IROut = ir; FlagsOut = fl;
    exp_q.push_back(exp);
    #1;
    check_val({nm, "_sc_t0"}, int'(SC), 0);
    check_cw({nm, "_fetch_l"}, fetch_cw(1'b0));
    @(negedge Clock); #1;
    check_val({nm, "_sc_t1"}, int'(SC), 1);
    check_cw({nm, "_fetch_h"}, fetch_cw(1'b1));
    do begin
      @(negedge Clock); #1;
      n++;
    end while (SC !== 3'd2 && n < 6);
    e = exp_q.pop_front();
    if (SC !== 3'd2) begin
      checks++; errors++;
      $display("FAIL %s_t2_timeout: SC got %0d required 2", nm, SC);
    end else begin
      check_cw({nm, "_exec"}, e);
      check_val({nm, "_halted_t2"}, int'(Halted), 0);
    end
    @(negedge Clock); #1;
  endtask

  initial begin
    // MOVL R3 <- 0x5A
    vecs[0].ir = 16'h4A5A; vecs[0].flags = 4'h0; vecs[0].exp = idle_cw();
    vecs[0].exp.ma = 2'b11; vecs[0].exp.rf_fun = 3'b101; vecs[0].exp.rf_reg = 4'b0100;
    // ADD dst1 <- 2 + 3
    vecs[1].ir = 16'h2853; vecs[1].flags = 4'h0; vecs[1].exp = idle_cw();
    vecs[1].exp.a_sel = 3'd2; vecs[1].exp.b_sel = 3'd3; vecs[1].exp.alu = 5'b00100;
    vecs[1].exp.wf = 1'b1; vecs[1].exp.rf_fun = 3'b010; vecs[1].exp.rf_reg = 4'b0010;
    // ADD into scratch S2 (dst code 5)
    vecs[2].ir = 16'h297C; vecs[2].flags = 4'h0; vecs[2].exp = idle_cw();
    vecs[2].exp.a_sel = 3'd7; vecs[2].exp.b_sel = 3'd4; vecs[2].exp.alu = 5'b00100;
    vecs[2].exp.wf = 1'b1; vecs[2].exp.rf_fun = 3'b010; vecs[2].exp.rf_scr = 4'b0010;
    // BNE 0x20 with Z=1: nothing happens
    vecs[3].ir = 16'h0820; vecs[3].flags = 4'b1000; vecs[3].exp = idle_cw();
    // BNE 0x20 with Z=0, other flags set: PC load
    vecs[4].ir = 16'h0820; vecs[4].flags = 4'b0111; vecs[4].exp = idle_cw();
    vecs[4].exp.mb = 2'b11; vecs[4].exp.arf_fun = 3'b010; vecs[4].exp.arf_reg = 3'b100;
    // BRA ignores Z
    vecs[5].ir = 16'h0033; vecs[5].flags = 4'b1000; vecs[5].exp = idle_cw();
    vecs[5].exp.mb = 2'b11; vecs[5].exp.arf_fun = 3'b010; vecs[5].exp.arf_reg = 3'b100;
    // LDB R2 <- M[AR]
    vecs[6].ir = 16'h4100; vecs[6].flags = 4'h0; vecs[6].exp = idle_cw();
    vecs[6].exp.d_sel = 2'b10; vecs[6].exp.cs = 1'b0; vecs[6].exp.ma = 2'b10;
    vecs[6].exp.rf_fun = 3'b100; vecs[6].exp.rf_reg = 4'b0010;
    // STB M[AR] <- R4
    vecs[7].ir = 16'h4700; vecs[7].flags = 4'h0; vecs[7].exp = idle_cw();
    vecs[7].exp.a_sel = 3'd3; vecs[7].exp.alu = 5'b00000; vecs[7].exp.mc = 1'b0;
    vecs[7].exp.d_sel = 2'b10; vecs[7].exp.cs = 1'b0; vecs[7].exp.wr = 1'b1;
    // MOVL R1 <- 0xFF
    vecs[8].ir = 16'h48FF; vecs[8].flags = 4'h0; vecs[8].exp = idle_cw();
    vecs[8].exp.ma = 2'b11; vecs[8].exp.rf_fun = 3'b101; vecs[8].exp.rf_reg = 4'b0001;
    // BNE with all flags clear
    vecs[9].ir = 16'h08AA; vecs[9].flags = 4'b0000; vecs[9].exp = idle_cw();
    vecs[9].exp.mb = 2'b11; vecs[9].exp.arf_fun = 3'b010; vecs[9].exp.arf_reg = 3'b100;

    // Reset and the single INIT clear cycle
    #12;
    check_cw("reset_init_word", init_cw());
    check_val("reset_sc", int'(SC), 0);
    check_val("reset_halted", int'(Halted), 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check_cw("init_after_release", init_cw());
    @(negedge Clock);

    for (int i = 0; i < 10; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].ir, vecs[i].flags, vecs[i].exp);

    // Undefined opcode 0x3E
    run_instr("undef3e", 16'hF800, 4'h0, idle_cw());
`ifdef CU_ILLEGAL_TRAP_EN
    check_val("undef3e_halted", int'(Halted), 1);
    check_cw("undef3e_idle", idle_cw());
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
`else
    check_val("undef3e_halted", int'(Halted), 0);
    check_cw("undef3e_next_fetch", fetch_cw(1'b0));
    run_instr("undef01", 16'h0400, 4'h0, idle_cw());
`endif

    // Reset pulled low during T1 of a store
    IROut = 16'h4700; FlagsOut = 4'h0;
    #1;
    @(negedge Clock); #1;
    check_val("midreset_sc_t1", int'(SC), 1);
    Reset = 1'b0;
    #1;
    check_cw("midreset_init_word", init_cw());
    check_val("midreset_sc", int'(SC), 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock); #1;
    check_cw("midreset_fetch_l", fetch_cw(1'b0));

    // HLT: parked with no fetch for 20 cycles
    run_instr("hlt", 16'hFC00, 4'h0, idle_cw());
    for (int c = 0; c < 20; c++) begin
      check_val($sformatf("hlt_halted_c%0d", c), int'(Halted), 1);
      check_cw($sformatf("hlt_idle_c%0d", c), idle_cw());
      @(negedge Clock); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
